// File: rtl/rc4_pkg.sv
// Shared RC4 keystream generator types and default sizing.
package rc4_pkg;
   localparam int RC4_WORD_W  = 4;
   localparam int RC4_KEY_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA,
      ST_GEN
   } rc4_state_e;
endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation store: two combinational read ports whose indices double as the
// swap write addresses, a post-swap lookup port and a registered debug read.
module rc4_sbox #(
   parameter int WORD_W = 4
) (
   input  logic              clk,
   input  logic              reset_1,
   input  logic [WORD_W-1:0] idx_a,
   input  logic [WORD_W-1:0] idx_b,
   output logic [WORD_W-1:0] data_a,
   output logic [WORD_W-1:0] data_b,
   input  logic              we_a,
   input  logic [WORD_W-1:0] wd_a,
   input  logic              we_b,
   input  logic [WORD_W-1:0] wd_b,
   input  logic [WORD_W-1:0] lk_idx,
   output logic [WORD_W-1:0] lk_data,
   input  logic [WORD_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);
   localparam int N = 1 << WORD_W;

   logic [WORD_W-1:0] mem [N];

   assign data_a = mem[idx_a];
   assign data_b = mem[idx_b];

   // Lookup sees the array as it will be after this cycle's swap of idx_a/idx_b.
   assign lk_data = (lk_idx == idx_a) ? mem[idx_b] :
                    (lk_idx == idx_b) ? mem[idx_a] : mem[lk_idx];

   always_ff @(posedge clk) begin
      if (we_a) mem[idx_a] <= wd_a;
      if (we_b) mem[idx_b] <= wd_b;
   end

   always_ff @(posedge clk) begin
      if (reset_1) rd_data <= '0;
      else         rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: key register file, S-box init, key scheduling and a
// one-word-per-cycle output stage with valid/ready back-pressure.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | waiting for start, key writes allowed
//   INIT    | N cycles writing S[c] = c
//   KSA     | N cycles of key-scheduling swaps
//   GEN     | producing keystream, key writes and restart allowed
module rc4_keystream_gen
   import rc4_pkg::*;
#(
   parameter int WORD_W  = RC4_WORD_W,
   parameter int KEY_MAX = RC4_KEY_MAX
) (
   input  logic                         clk,
   input  logic                         reset_1,
   input  logic                         key_we,
   input  logic [$clog2(KEY_MAX)-1:0]   key_addr,
   input  logic [WORD_W-1:0]            key_data,
   input  logic [$clog2(KEY_MAX):0]     key_len,
   input  logic                         start,
   output logic                         ks_valid,
   input  logic                         ks_ready,
   output logic [WORD_W-1:0]            ks_data,
   output logic                         busy,
   input  logic [WORD_W-1:0]            rd_addr,
   output logic [WORD_W-1:0]            rd_data
);
   localparam int KA_W = $clog2(KEY_MAX);
   localparam int KL_W = KA_W + 1;
   localparam logic [KL_W-1:0] KEY_MAX_L = KL_W'(KEY_MAX);

   rc4_state_e        state, state_nx;
   logic [WORD_W-1:0] i, i_nx, j, j_nx;
   logic [KA_W-1:0]   k, k_nx, len_m1, len_m1_nx, len_m1_start;
   logic              ks_valid_nx;
   logic [WORD_W-1:0] ks_data_nx;
   logic [WORD_W-1:0] key_q [KEY_MAX];

   logic [WORD_W-1:0] ra_idx, ra_data, rb_data, j_step, lk_idx, lk_data;
   logic [WORD_W-1:0] sb_wd_a, sb_wd_b;
   logic              sb_we_a, sb_we_b, start_ok, key_open;

   assign key_open = (state == ST_IDLE) || (state == ST_GEN);
   assign start_ok = start && key_open;
   assign busy     = (state == ST_INIT) || (state == ST_KSA);

   assign len_m1_start = (key_len == '0 || key_len > KEY_MAX_L) ? KA_W'(KEY_MAX - 1)
                                                                : KA_W'(key_len - 1'b1);

   // Port A reads S[i] while scheduling, S[i+1] while generating; port B follows j.
   assign ra_idx = (state == ST_GEN) ? i + 1'b1 : i;
   assign j_step = j + ra_data + ((state == ST_KSA) ? key_q[k] : '0);
   assign lk_idx = ra_data + rb_data;

   rc4_sbox #(.WORD_W(WORD_W)) u_sbox (
      .clk     (clk),
      .reset_1 (reset_1),
      .idx_a   (ra_idx),
      .idx_b   (j_step),
      .data_a  (ra_data),
      .data_b  (rb_data),
      .we_a    (sb_we_a & ~reset_1),
      .wd_a    (sb_wd_a),
      .we_b    (sb_we_b & ~reset_1),
      .wd_b    (sb_wd_b),
      .lk_idx  (lk_idx),
      .lk_data (lk_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nx    = state;
      i_nx        = i;
      j_nx        = j;
      k_nx        = k;
      len_m1_nx   = len_m1;
      ks_valid_nx = ks_valid;
      ks_data_nx  = ks_data;
      sb_we_a     = 1'b0;
      sb_we_b     = 1'b0;
      sb_wd_a     = rb_data;
      sb_wd_b     = ra_data;
      if (start_ok) begin
         state_nx    = ST_INIT;
         i_nx        = '0;
         j_nx        = '0;
         k_nx        = '0;
         len_m1_nx   = len_m1_start;
         ks_valid_nx = 1'b0;
      end else begin
         unique case (state)
            ST_INIT: begin
               sb_we_a = 1'b1;
               sb_wd_a = i;
               i_nx    = i + 1'b1;
               if (i == '1) state_nx = ST_KSA;
            end
            ST_KSA: begin
               sb_we_a = 1'b1;
               sb_we_b = 1'b1;
               i_nx    = i + 1'b1;
               j_nx    = j_step;
               k_nx    = (k == len_m1) ? '0 : k + 1'b1;
               if (i == '1) begin
                  state_nx = ST_GEN;
                  j_nx     = '0;
               end
            end
            ST_GEN: begin
               if (!ks_valid || ks_ready) begin
                  sb_we_a     = 1'b1;
                  sb_we_b     = 1'b1;
                  i_nx        = ra_idx;
                  j_nx        = j_step;
                  ks_data_nx  = lk_data;
                  ks_valid_nx = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_1) begin
         state    <= ST_IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         len_m1   <= '0;
         ks_valid <= 1'b0;
         ks_data  <= '0;
      end else begin
         state    <= state_nx;
         i        <= i_nx;
         j        <= j_nx;
         k        <= k_nx;
         len_m1   <= len_m1_nx;
         ks_valid <= ks_valid_nx;
         ks_data  <= ks_data_nx;
      end
   end

   // Key contents survive reset; only the write strobe is blocked by it.
   always_ff @(posedge clk) begin
      if (!reset_1 && key_we && key_open) key_q[key_addr] <= key_data;
   end
endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Bench for rc4_keystream_gen: known-answer table on an 8-bit instance, corner
// sequences and randomized keys on both a 4-bit and an 8-bit instance.
module tb_rc4_keystream_gen;
   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // index 0 drives the WORD_W=4 instance, index 1 the WORD_W=8 instance
   logic       reset_v    [2];
   logic       key_we_v   [2];
   logic [3:0] key_addr_v [2];
   logic [7:0] key_data_v [2];
   logic [4:0] key_len_v  [2];
   logic       start_v    [2];
   logic       ks_ready_v [2];
   logic [7:0] rd_addr_v  [2];

   logic       valid4, valid8, busy4, busy8;
   logic [3:0] data4, rdd4;
   logic [7:0] data8, rdd8;

   rc4_keystream_gen #(.WORD_W(4), .KEY_MAX(16)) dut4 (
      .clk(clk), .reset_1(reset_v[0]), .key_we(key_we_v[0]), .key_addr(key_addr_v[0]),
      .key_data(key_data_v[0][3:0]), .key_len(key_len_v[0]), .start(start_v[0]),
      .ks_valid(valid4), .ks_ready(ks_ready_v[0]), .ks_data(data4), .busy(busy4),
      .rd_addr(rd_addr_v[0][3:0]), .rd_data(rdd4));

   rc4_keystream_gen #(.WORD_W(8), .KEY_MAX(16)) dut8 (
      .clk(clk), .reset_1(reset_v[1]), .key_we(key_we_v[1]), .key_addr(key_addr_v[1]),
      .key_data(key_data_v[1]), .key_len(key_len_v[1]), .start(start_v[1]),
      .ks_valid(valid8), .ks_ready(ks_ready_v[1]), .ks_data(data8), .busy(busy8),
      .rd_addr(rd_addr_v[1]), .rd_data(rdd8));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int ref_key [16];
   int exp_q [$];

   typedef struct {
      int len;
      int key   [4];
      int nexp;
      int exp_w [10];
      int mode;
   } vec_t;
   vec_t tv [3];

   function automatic logic get_valid(int d); return d ? valid8 : valid4; endfunction
   function automatic logic get_busy(int d);  return d ? busy8 : busy4;   endfunction
   function automatic int get_data(int d);    return d ? int'(data8) : int'(data4); endfunction
   function automatic int get_rdd(int d);     return d ? int'(rdd8) : int'(rdd4);   endfunction
   function automatic int eff_len(int len);   return (len == 0 || len > 16) ? 16 : len; endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Plain RC4 from its definition: identity fill, key schedule, then generation.
   task automatic ref_gen(input int w, input int len, input int cnt);
      int n, s[256], ii, jj, t;
      n = 1 << w;
      exp_q.delete();
      for (int c = 0; c < n; c++) s[c] = c;
      jj = 0;
      for (int c = 0; c < n; c++) begin
         jj = (jj + s[c] + ref_key[c % len]) % n;
         t = s[c]; s[c] = s[jj]; s[jj] = t;
      end
      ii = 0; jj = 0;
      for (int c = 0; c < cnt; c++) begin
         ii = (ii + 1) % n;
         jj = (jj + s[ii]) % n;
         t = s[ii]; s[ii] = s[jj]; s[jj] = t;
         exp_q.push_back(s[(s[ii] + s[jj]) % n]);
      end
   endtask

   task automatic load_key(input int d, input int nwords);
      for (int a = 0; a < nwords; a++) begin
         key_we_v[d]   = 1'b1;
         key_addr_v[d] = 4'(a);
         key_data_v[d] = 8'(ref_key[a]);
         step();
      end
      key_we_v[d] = 1'b0;
   endtask

   task automatic pulse_start(input int d, input int len);
      key_len_v[d] = 5'(len);
      start_v[d]   = 1'b1;
      step();
      start_v[d]   = 1'b0;
      cyc = 0;
      chk("busy_after_start", int'(get_busy(d)), 1);
      chk("valid_after_start", int'(get_valid(d)), 0);
   endtask

   task automatic wait_valid(input int d, input int lat);
      while (!get_valid(d) && cyc < 2000) step();
      chk("first_valid_cycle", cyc, lat);
   endtask

   // mode 0: ready held high, 1: ready toggles, 2: random ready
   task automatic collect(input int d, input int mode, input int n);
      int got = 0, budget = 0, held = 0;
      bit stalled = 0, rdy;
      while (got < n && budget < 4000) begin
         if (stalled) begin
            chk("hold_valid", int'(get_valid(d)), 1);
            chk("hold_data", get_data(d), held);
         end
         if (mode == 0 && got > 0) chk("no_gap", int'(get_valid(d)), 1);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (budget % 2) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         ks_ready_v[d] = rdy;
         stalled = 0;
         if (get_valid(d)) begin
            if (rdy) begin
               chk($sformatf("ks_word[%0d]", got), get_data(d), exp_q[got]);
               got++;
            end else begin
               held = get_data(d);
               stalled = 1;
            end
         end
         step();
         budget++;
      end
      if (got < n) chk("collect_timeout_words", got, n);
      ks_ready_v[d] = 1'b1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset_v[d] = 1'b1; key_we_v[d] = 1'b0; key_addr_v[d] = '0; key_data_v[d] = '0;
         key_len_v[d] = '0; start_v[d] = 1'b0; ks_ready_v[d] = 1'b1; rd_addr_v[d] = '0;
      end
      tv[0] = '{3, '{'h4B, 'h65, 'h79, 0}, 10,
                '{'hEB, 'h9F, 'h77, 'h81, 'hB7, 'h34, 'hCA, 'h72, 'hA7, 'h19}, 0};
      tv[1] = '{4, '{'h57, 'h69, 'h6B, 'h69}, 6, '{'h60, 'h44, 'hDB, 'h6D, 'h41, 'hB7, 0, 0, 0, 0}, 0};
      tv[2] = '{4, '{'h57, 'h69, 'h6B, 'h69}, 6, '{'h60, 'h44, 'hDB, 'h6D, 'h41, 'hB7, 0, 0, 0, 0}, 1};

      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         chk("reset_valid", int'(get_valid(d)), 0);
         chk("reset_busy", int'(get_busy(d)), 0);
         chk("reset_data", get_data(d), 0);
         chk("reset_rd_data", get_rdd(d), 0);
         reset_v[d] = 1'b0;
      end
      repeat (4) step();
      chk("idle_no_output", int'(valid4 | valid8), 0);

      // known-answer vectors on the 8-bit instance
      for (int t = 0; t < 3; t++) begin
         for (int a = 0; a < 4; a++) ref_key[a] = tv[t].key[a];
         load_key(1, tv[t].len);
         exp_q.delete();
         for (int e = 0; e < tv[t].nexp; e++) exp_q.push_back(tv[t].exp_w[e]);
         pulse_start(1, tv[t].len);
         wait_valid(1, 513);
         collect(1, tv[t].mode, tv[t].nexp);
      end

      // reset at INIT cycle 5, then a fresh start reproduces the unreset stream
      for (int a = 0; a < 16; a++) ref_key[a] = $urandom_range(0, 15);
      load_key(0, 5);
      ref_gen(4, 5, 20);
      pulse_start(0, 5);
      repeat (5) step();
      reset_v[0] = 1'b1;
      step();
      reset_v[0] = 1'b0;
      chk("midinit_reset_valid", int'(valid4), 0);
      chk("midinit_reset_busy", int'(busy4), 0);
      pulse_start(0, 5);
      wait_valid(0, 33);
      collect(0, 0, 20);

      // key write during INIT and start during KSA are both ignored
      for (int a = 0; a < 16; a++) ref_key[a] = $urandom_range(0, 15);
      load_key(0, 3);
      ref_gen(4, 3, 20);
      pulse_start(0, 3);
      repeat (2) step();
      key_we_v[0] = 1'b1; key_addr_v[0] = 4'd0; key_data_v[0] = 8'(ref_key[0] ^ 5);
      step();
      key_we_v[0] = 1'b0;
      while (cyc < 19) step();
      chk("busy_in_ksa", int'(busy4), 1);
      start_v[0] = 1'b1; key_len_v[0] = 5'd1;
      step();
      start_v[0] = 1'b0;
      chk("busy_after_ignored_start", int'(busy4), 1);
      wait_valid(0, 33);
      collect(0, 0, 20);

      // key_len=0 means 16; identity S-box visible after the INIT period
      for (int a = 0; a < 16; a++) ref_key[a] = $urandom_range(0, 15);
      load_key(0, 16);
      pulse_start(0, 0);
      while (cyc < 16) step();
      reset_v[0] = 1'b1;
      step();
      reset_v[0] = 1'b0;
      for (int a = 0; a < 16; a++) begin
         rd_addr_v[0] = 8'(a);
         step();
         chk($sformatf("rd_sweep[%0d]", a), int'(rdd4), a);
      end
      ref_gen(4, 16, 32);
      pulse_start(0, 0);
      wait_valid(0, 33);
      collect(0, 1, 32);

      // randomized keys, lengths (including out-of-range) and back-pressure
      for (int it = 0; it < 8; it++) begin
         int d, w, len;
         d   = it % 2;
         w   = d ? 8 : 4;
         len = $urandom_range(0, 31);
         for (int a = 0; a < 16; a++) ref_key[a] = $urandom_range(0, (1 << w) - 1);
         load_key(d, 16);
         ref_gen(w, eff_len(len), 24);
         pulse_start(d, len);
         wait_valid(d, 2 * (1 << w) + 1);
         collect(d, 2, 24);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rc4_keystream_gen.md
RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

Interface
REQ-001 SHALL have parameter WORD_W, default 4: word width in bits; S-box depth N = 2^WORD_W.
REQ-002 SHALL have parameter KEY_MAX, default 16: key register file depth in words.
REQ-003 SHALL have port clk  input  1: the only clock, all logic on rising edge.
REQ-004 SHALL have port reset_1  input  1: synchronous, active-high reset.
REQ-005 SHALL have port key_we  input  1: key word write strobe.
REQ-006 SHALL have port key_addr  input  clog2(KEY_MAX): key word index.
REQ-007 SHALL have port key_data  input  WORD_W: key word value.
REQ-008 SHALL have port key_len  input  clog2(KEY_MAX)+1: key length in words, sampled on an accepted start; 0 or >KEY_MAX treated as KEY_MAX.
REQ-009 SHALL have port start  input  1: one-cycle request to (re)key and begin generation.
REQ-010 SHALL have port ks_valid  output  1: ks_data holds an unconsumed keystream word.
REQ-011 SHALL have port ks_ready  input  1: consumer accepts ks_data when ks_valid&&ks_ready.
REQ-012 SHALL have port ks_data  output  WORD_W: keystream word.
REQ-013 SHALL have port busy  output  1: high in INIT or KSA.
REQ-014 SHALL have port rd_addr  input  WORD_W: S-box debug read index.
REQ-015 SHALL have port rd_data  output  WORD_W: registered S[rd_addr], one-cycle latency.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, KSA, GEN; all arithmetic modulo 2^WORD_W.
REQ-017 key_we SHALL write key[key_addr]<=key_data only in IDLE or GEN; writes in INIT/KSA are ignored.
REQ-018 start SHALL be accepted in IDLE or GEN (abandoning any pending output, ks_valid<=0) and ignored in INIT/KSA.
REQ-019 INIT SHALL last exactly N cycles, writing S[c]<=c for c=0..N-1.
REQ-020 KSA SHALL last exactly N cycles, one swap per cycle: j<=j+S[i]+key[i mod len]; swap S[i],S[j]; i,j start at 0.
REQ-021 On KSA exit SHALL set i=j=0 and enter GEN.
REQ-022 In GEN, when output register empty or being consumed this cycle, SHALL in one cycle: i'=i+1; j'=j+S[i']; swap S[i'],S[j']; ks_data<=S[(S[i']+S[j']) mod N] (post-swap values); ks_valid<=1.
REQ-023 When ks_valid&&!ks_ready, ks_data, i, j and S SHALL hold unchanged.
REQ-024 With ks_ready held high, SHALL produce one word per cycle; first ks_valid asserted 2N+1 cycles after the accepting edge of start.
REQ-025 Swap with i'==j' SHALL leave S unchanged.
REQ-026 rd_data SHALL reflect S after any same-cycle write of the previous edge (read of registered array, no bypass).

Reset
REQ-027 reset_1 SHALL force IDLE, ks_valid=0, ks_data=0, busy=0, rd_data=0, i=j=0 at the next edge, including mid-INIT/KSA/GEN.
REQ-028 S-box and key contents SHALL NOT be reset; a start is required before valid output.
REQ-029 reset_1 SHALL take priority over start and key_we in the same cycle.

Structure
REQ-030 Package rc4_pkg SHALL hold the FSM state enum and default WORD_W/KEY_MAX constants.
REQ-031 S-box SHALL be sub-module rc4_sbox: N x WORD_W register array, two combinational read ports, dual-index swap write, registered debug read.
REQ-032 Implementation SHALL fit 120-400 RTL lines and be free of latches and multiple drivers.

Verification
REQ-033 WORD_W=8, key "Key"(4B 65 79), len 3, ks_ready=1 -> first 10 words EB 9F 77 81 B7 34 CA 72 A7 19, first at cycle 513.
REQ-034 WORD_W=8, key "Wiki"(57 69 6B 69), len 4 -> 60 44 DB 6D 41 B7; ks_ready toggled 1/0 -> same sequence, no word lost or repeated.
REQ-035 WORD_W=4, start then reset_1 at INIT cycle 5 -> ks_valid=0, busy=0 next edge; new start gives identical stream to an unreset run.
REQ-036 start during KSA and key_we during INIT -> both ignored; stream matches the original key.
REQ-037 key_len=0, KEY_MAX=16, WORD_W=4 -> stream matches reference model with len 16; rd_addr sweep 0..15 after INIT-only period reads 0..15.
